// File: rtl/module_result_display_pkg.sv
// Shared types and seven-segment constants for the result display path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package pkg_display;

  typedef enum logic [1:0] {IDLE, CONV, DONE} disp_state_t;

  // Scratch BCD digits kept by the converter; enough for 65535.
  localparam int SCR_DIG = 5;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/module_result_display_if.sv
// Load/result handshake plus display pins of the result display block.
interface module_result_display_if #(
  parameter int WIDTH = 16,
  parameter int NDIG  = 4
);
  logic [WIDTH-1:0]  valor;
  logic              cargar;
  logic              ocupado;
  logic              listo_bcd;
  logic [4*NDIG-1:0] bcd;
  logic              overflow;
  logic [NDIG-1:0]   anodos;
  logic [6:0]        segmentos;

  modport slave (
    input  valor, cargar,
    output ocupado, listo_bcd, bcd, overflow, anodos, segmentos
  );

  modport master (
    output valor, cargar,
    input  ocupado, listo_bcd, bcd, overflow, anodos, segmentos
  );
endinterface

// File: rtl/module_result_display_bin2bcd_dd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Results are published only in DONE, so bcd never exposes a partial conversion.
module module_bin2bcd_dd
  import pkg_display::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [WIDTH-1:0]  i_valor,
  input  logic              i_cargar,
  output logic [4*NDIG-1:0] o_bcd,
  output logic              o_overflow,
  output logic              o_ocupado,
  output logic              o_listo_bcd
);

  localparam int SCR_W = 4 * SCR_DIG;
  localparam int CNT_W = $clog2(WIDTH + 1);

  disp_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_sh;
  logic [SCR_W-1:0]  r_scr;
  logic [SCR_W-1:0]  w_adj;
  logic [4*NDIG-1:0] r_bcd;
  logic              r_ovf;
  logic              r_listo;

  // Per-digit add-3 correction; 4-bit adds, no carry between digits.
  function automatic logic [SCR_W-1:0] dd_adjust(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] a;
    a = s;
    for (int i = 0; i < SCR_DIG; i++) begin
      if (s[4*i +: 4] >= 4'd5)
        a[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return a;
  endfunction

  assign w_adj = dd_adjust(r_scr);

  // p0: control FSM and published result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_listo <= 1'b0;
    end else begin
      r_listo <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cargar) begin
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= CONV;
          end
        end
        CONV: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1))
            r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_scr[4*NDIG-1:0];
          r_ovf   <= |(r_scr >> (4 * NDIG));
          r_listo <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // p0: shift/scratch datapath, reloaded on every accepted load
  always_ff @(posedge i_clk) begin
    if (r_state == IDLE && i_cargar) begin
      r_sh  <= i_valor;
      r_scr <= '0;
    end else if (r_state == CONV) begin
      r_scr <= {w_adj[SCR_W-2:0], r_sh[WIDTH-1]};
      r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign o_bcd       = r_bcd;
  assign o_overflow  = r_ovf;
  assign o_listo_bcd = r_listo;
  assign o_ocupado   = (r_state != IDLE);

endmodule

// File: rtl/module_result_display.sv
// Result display: converts the binary result to BCD and scans a
// common-anode multiplexed seven-segment display with leading-zero blanking.
module module_result_display
  import pkg_display::*;
#(
  parameter int WIDTH       = 16,
  parameter int NDIG        = 4,
  parameter int REFRESH_CYC = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  module_result_display_if.slave  bus
);

  localparam int REF_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [4*NDIG-1:0] w_bcd;
  logic              w_ovf;
  logic              w_ocupado;
  logic              w_listo;

  logic [REF_W-1:0]  r_ref;
  logic [IDX_W-1:0]  r_idx;
  logic [NDIG-1:0]   r_anodos;
  logic [6:0]        r_seg;

  logic [3:0]        w_dig;
  logic              w_blank;
  logic              w_hi_zero;
  logic [6:0]        w_seg;

  module_bin2bcd_dd #(
    .WIDTH (WIDTH),
    .NDIG  (NDIG)
  ) u_bin2bcd (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_valor     (bus.valor),
    .i_cargar    (bus.cargar),
    .o_bcd       (w_bcd),
    .o_overflow  (w_ovf),
    .o_ocupado   (w_ocupado),
    .o_listo_bcd (w_listo)
  );

  // Walk from the top digit down so w_hi_zero means "this and all higher digits are 0".
  always_comb begin
    w_hi_zero = 1'b1;
    w_dig     = 4'd0;
    w_blank   = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_hi_zero = w_hi_zero && (w_bcd[4*i +: 4] == 4'd0);
      if (r_idx == IDX_W'(i)) begin
        w_dig   = w_bcd[4*i +: 4];
        w_blank = (BLANK_LZ != 0) && (i > 0) && w_hi_zero;
      end
    end
    if (w_ovf)
      w_seg = SEG_DASH;
    else if (w_blank)
      w_seg = SEG_BLANK;
    else
      w_seg = seg_decode(w_dig);
  end

  // p1: refresh timer, digit scan and registered display pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ref    <= '0;
      r_idx    <= '0;
      r_anodos <= '1;
      r_seg    <= SEG_BLANK;
    end else begin
      r_anodos <= ~(NDIG'(1) << r_idx);
      r_seg    <= w_seg;
      if (r_ref == REF_W'(REFRESH_CYC - 1)) begin
        r_ref <= '0;
        r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_ref <= r_ref + 1'b1;
      end
    end
  end

  assign bus.bcd       = w_bcd;
  assign bus.overflow  = w_ovf;
  assign bus.ocupado   = w_ocupado;
  assign bus.listo_bcd = w_listo;
  assign bus.anodos    = r_anodos;
  assign bus.segmentos = r_seg;

endmodule
